// File: rtl/arm_dp_encoder_pkg.sv
// Shared types and constants for the ARM data-processing / SWI encoder.
package arm_enc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } enc_state_e;

    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;
    localparam logic [3:0] SWI_OPC = 4'b1111;

    localparam logic [3:0] OPD_AND = 4'b0000;
    localparam logic [3:0] OPD_EOR = 4'b0001;
    localparam logic [3:0] OPD_SUB = 4'b0010;
    localparam logic [3:0] OPD_RSB = 4'b0011;
    localparam logic [3:0] OPD_ADD = 4'b0100;
    localparam logic [3:0] OPD_ADC = 4'b0101;
    localparam logic [3:0] OPD_SBC = 4'b0110;
    localparam logic [3:0] OPD_RSC = 4'b0111;
    localparam logic [3:0] OPD_TST = 4'b1000;
    localparam logic [3:0] OPD_TEQ = 4'b1001;
    localparam logic [3:0] OPD_CMP = 4'b1010;
    localparam logic [3:0] OPD_CMN = 4'b1011;
    localparam logic [3:0] OPD_ORR = 4'b1100;
    localparam logic [3:0] OPD_MOV = 4'b1101;
    localparam logic [3:0] OPD_BIC = 4'b1110;
    localparam logic [3:0] OPD_MVN = 4'b1111;

    // Bit positions within the 32-bit instruction word
    localparam int unsigned F_COND_LSB = 28;
    localparam int unsigned F_SWI_LSB  = 24;
    localparam int unsigned F_I_BIT    = 25;
    localparam int unsigned F_OPC_LSB  = 21;
    localparam int unsigned F_S_BIT    = 20;
    localparam int unsigned F_RN_LSB   = 16;
    localparam int unsigned F_RD_LSB   = 12;

    // TST/TEQ/CMP/CMN: flag-setting compares with no destination
    function automatic logic is_test_op(input logic [3:0] opc);
        return (opc[3:2] == 2'b10);
    endfunction

    // MOV/MVN: single-operand moves with no first operand
    function automatic logic is_move_op(input logic [3:0] opc);
        return (opc == OPD_MOV) || (opc == OPD_MVN);
    endfunction

endpackage

// File: rtl/arm_dp_encoder_if.sv
// Request / instruction-stream bundle between a program generator and the encoder.
interface arm_dp_encoder_if;
    logic        start;
    logic        req_valid;
    logic        req_ready;
    logic        req_swi;
    logic [3:0]  req_cond;
    logic [3:0]  req_opcode;
    logic        req_imm;
    logic        req_s;
    logic [3:0]  req_rn;
    logic [3:0]  req_rd;
    logic [11:0] req_op2;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_word;
    logic [31:0] inst_addr;
    logic        done;
    logic [15:0] count;
    logic        err;

    modport master (
        output start, req_valid, req_swi, req_cond, req_opcode, req_imm, req_s,
               req_rn, req_rd, req_op2, inst_ready,
        input  req_ready, inst_valid, inst_word, inst_addr, done, count, err
    );

    modport slave (
        input  start, req_valid, req_swi, req_cond, req_opcode, req_imm, req_s,
               req_rn, req_rd, req_op2, inst_ready,
        output req_ready, inst_valid, inst_word, inst_addr, done, count, err
    );
endinterface

// File: rtl/arm_dp_encoder_fifo.sv
// Small synchronous FIFO (power-of-two depth) holding encoded words.
module arm_enc_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance on accepted push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers; reset empties the FIFO
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents beyond the pointers are don't-care
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/arm_dp_encoder.sv
// ARM data-processing / SWI instruction encoder with output FIFO and address counter.
// Optional macro ARM_DP_ENC_CHECK_EN: rewrite NV condition to AL and raise sticky err.
module arm_dp_encoder
    import arm_enc_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_b,
    arm_dp_encoder_if.slave  bus
);
    enc_state_e  state_q, state_d;
    logic        req_ready, done;
    logic        accept, pop, start_ok;
    logic        fifo_full, fifo_empty;
    logic [31:0] enc_word, head_word;
    logic [31:0] addr_q, addr_d;
    logic [15:0] count_q, count_d;
    logic [3:0]  cond_eff;

    assign accept   = bus.req_valid && req_ready;
    assign pop      = !fifo_empty && bus.inst_ready;
    assign start_ok = bus.start && ((state_q == IDLE) || (state_q == DONE));

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start)            state_d = ACTIVE;
            ACTIVE:  if (accept && bus.req_swi) state_d = DRAIN;
            DRAIN:   if (fifo_empty)            state_d = DONE;
            DONE:    if (bus.start)            state_d = ACTIVE;
            default:                            state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        req_ready = (state_q == ACTIVE) && !fifo_full;
        done      = (state_q == DONE);
    end

    // Field packing with opcode-class normalisation
    always_comb begin
        cond_eff = bus.req_cond;
`ifdef ARM_DP_ENC_CHECK_EN
        if (bus.req_cond == COND_NV) cond_eff = COND_AL;
`endif
        enc_word                     = '0;
        enc_word[F_COND_LSB +: 4]    = cond_eff;
        enc_word[F_RD_LSB +: 4]      = bus.req_rd;
        enc_word[F_RN_LSB +: 4]      = bus.req_rn;
        enc_word[11:0]               = bus.req_op2;
        if (bus.req_swi) begin
            enc_word[F_SWI_LSB +: 4] = SWI_OPC;
        end else begin
            enc_word[F_I_BIT]        = bus.req_imm;
            enc_word[F_OPC_LSB +: 4] = bus.req_opcode;
            enc_word[F_S_BIT]        = bus.req_s;
            if (is_test_op(bus.req_opcode)) begin
                enc_word[F_S_BIT]       = 1'b1;
                enc_word[F_RD_LSB +: 4] = 4'h0;
            end
            if (is_move_op(bus.req_opcode)) enc_word[F_RN_LSB +: 4] = 4'h0;
        end
    end

    arm_enc_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .push      (accept),
        .push_data (enc_word),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_word)
    );

    // Address and emitted-word counter updates
    always_comb begin
        addr_d  = addr_q;
        count_d = count_q;
        if (start_ok) begin
            addr_d  = BASE_ADDR;
            count_d = '0;
        end else if (pop) begin
            addr_d = addr_q + 32'd4;
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end
    end

    // Address and counter registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            addr_q  <= BASE_ADDR;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

`ifdef ARM_DP_ENC_CHECK_EN
    logic err_q, err_d;

    // Sticky illegal-condition flag, cleared by a new program
    always_comb begin
        err_d = err_q;
        if (start_ok)                            err_d = 1'b0;
        else if (accept && bus.req_cond == COND_NV) err_d = 1'b1;
    end

    // Error flag register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.req_ready  = req_ready;
    assign bus.done       = done;
    assign bus.inst_valid = !fifo_empty;
    assign bus.inst_word  = fifo_empty ? '0 : head_word;
    assign bus.inst_addr  = addr_q;
    assign bus.count      = count_q;
endmodule

// File: doc/arm_dp_encoder.md
Name: arm_dp_encoder

Overview:
Encoder counterpart to the instruction decoder. It accepts field-level requests for ARM data-processing and SWI instructions and packs them into 32-bit instruction words. Words pass through a small FIFO and are streamed, with a running word address, to the instruction-memory loader. Used for bring-up and self-test program generation.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
BASE_ADDR, 32'h0000_0000, byte address of first emitted word

Ports:
clk  in  1  clock
rst_b  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin new program at BASE_ADDR
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_swi  in  1  encode SWI instead of data-processing
req_cond  in  4  condition field
req_opcode  in  4  DP opcode (OPD_* encoding)
req_imm  in  1  I bit
req_s  in  1  S bit
req_rn  in  4  Rn
req_rd  in  4  Rd
req_op2  in  12  operand2
inst_valid  out  1  inst_word/inst_addr valid
inst_ready  in  1  consumer ready
inst_word  out  32  encoded instruction
inst_addr  out  32  byte address of inst_word
done  out  1  program complete (level)
count  out  16  words emitted since start
err  out  1  sticky illegal-field flag (optional feature)

Behaviour:
- Reset (async, rst_b=0): state IDLE; FIFO emptied; req_ready=0, inst_valid=0, inst_word=0, inst_addr=BASE_ADDR, done=0, count=0, err=0. Reset mid-operation discards all buffered words.
- FSM: IDLE -(start)-> ACTIVE; ACTIVE -(accepted req with req_swi=1)-> DRAIN; DRAIN -(FIFO empty)-> DONE; DONE -(start)-> ACTIVE. start in ACTIVE/DRAIN is ignored. start resets inst_addr to BASE_ADDR, count to 0, and err to 0.
- req_ready = (state==ACTIVE) && !full. No push when full, even with a simultaneous pop.
- DP encoding: {cond, 2'b00, I, opcode, S, Rn, Rd, op2}.
- Normalisation: TST/TEQ/CMP/CMN (1000-1011) force S=1 and Rd=0. MOV/MVN (1101, 1111) force Rn=0.
- SWI encoding: {cond, 4'b1111, 4'h0, Rn, Rd, op2}.
- Encoding is combinational from request fields. The word is written into the FIFO on accept. Earliest inst_valid is the cycle after accept.
- inst_valid = !empty. inst_word is the FIFO head, held stable while inst_valid&&!inst_ready.
- Pop on inst_valid&&inst_ready: inst_addr += 4 (wraps modulo 2^32), count += 1 (saturates at 16'hFFFF).
- Simultaneous push and pop when not full: both occur, and occupancy is unchanged.
- done=1 only in DONE. inst_valid is never asserted in DONE.

Optional Feature:
Macro ARM_DP_ENC_CHECK_EN.
- Defined: req_cond==4'b1111 (NV) is replaced by 4'b1110 (AL), and err is set on that accept. err is sticky until reset or start.
- Undefined: cond passes through unchanged, and err is tied to 0.

Decomposition:
- Package arm_enc_pkg: state enum typedef (IDLE, ACTIVE, DRAIN, DONE), COND_AL/COND_NV constants, SWI_OPC (4'b1111), field-position localparams, and is_test_op/is_move_op functions.
- Opcode values reuse the existing OPD_* defines.
- One sub-module: arm_enc_fifo, a parameterised synchronous FIFO with async active-low reset, push/pop, full/empty, and head data.

Test Plan:
- start; ADD cond=E I=1 S=0 Rn=1 Rd=2 op2=0x005 -> inst_word=0xE2812005, inst_addr=0x0, valid 1 cycle after accept.
- CMP cond=E I=1 S=0 Rn=3 Rd=7 op2=0x00A -> 0xE353000A (S forced 1, Rd forced 0).
- MOV cond=E I=0 S=1 Rn=5 Rd=4 op2=0x001 -> 0xE1B04001 (Rn forced 0).
- DEPTH=4, inst_ready=0, offer 5 requests -> req_ready drops after 4. Raise inst_ready -> addrs 0x0,0x4,0x8,0xC, then the 5th at 0x10, with word order preserved.
- SWI cond=E, fields 0 -> 0xEF000000. req_ready=0 afterward; done=1 once FIFO drains; count equals total words.
- With 3 words buffered, pulse rst_b low -> inst_valid=0, done=0, count=0 immediately. After start, first word at BASE_ADDR.
- ARM_DP_ENC_CHECK_EN: cond=F ADD -> word 0xE..., err=1 and held until start.
